// File: rtl/axi_chk_pkg.sv
// Shared types and constants for the AXI write-slave checker.
package axi_chk_pkg;

    localparam int PATTERN_WORD_W = 32;

    // Queue entries carry IDs at this fixed width; narrower AXI IDs are zero-extended.
    localparam int ID_W_MAX = 16;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        logic [7:0]          len;
    } aw_entry_t;

    typedef struct packed {
        logic [ID_W_MAX-1:0] id;
        logic                err;
    } b_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, pointers and full/empty flags.
module sync_fifo #(
    parameter int          WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    assign count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    assign rdata      = mem[rd_ptr];

    // Entry storage; cleared on reset so the head reads as zero while empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, occupancy and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/axi_wr_slave_checker.sv
// AXI4 write slave that terminates bursts, checks beat count, WLAST, strobes
// and an incrementing 32-bit data pattern, and answers B in order.
module axi_wr_slave_checker #(
    parameter int ID_WIDTH     = 2,
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 512,
    parameter int AWUSER_WIDTH = 8,
    parameter int OUTSTANDING  = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic [ID_WIDTH-1:0]       s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic [AWUSER_WIDTH-1:0]   s_axi_awuser,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,

    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,

    output logic [ID_WIDTH-1:0]       s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,

    input  logic                      chk_start_pulse,
    input  logic [31:0]               chk_init_data,
    input  logic [31:0]               chk_number,
    output logic [39:0]               beats_received,
    output logic [31:0]               bursts_done,
    output logic                      data_error,
    output logic                      proto_error,
    output logic [39:0]               first_err_beat,
    output logic                      done_pulse
);

    import axi_chk_pkg::*;

    aw_entry_t aw_in;
    aw_entry_t aw_head;
    b_entry_t  b_in;
    b_entry_t  b_head;
    logic      aw_full;
    logic      aw_empty;
    logic      b_full;
    logic      b_empty;

    logic        aw_push;
    logic        beat;
    logic        is_last;
    logic        burst_end;
    logic        b_pop;
    logic        data_bad;
    logic        proto_bad;
    logic        beat_err;
    logic [7:0]  beat_idx;
    logic        burst_bad;
    logic [31:0] expected;

    assign aw_in = '{id: ID_W_MAX'(s_axi_awid), len: s_axi_awlen};
    assign b_in  = '{id: aw_head.id, err: burst_bad || beat_err};

    assign aw_push   = s_axi_awvalid && s_axi_awready;
    assign beat      = s_axi_wvalid && s_axi_wready;
    assign is_last   = (beat_idx == aw_head.len);
    assign burst_end = beat && is_last;
    assign b_pop     = s_axi_bvalid && s_axi_bready;

    assign data_bad  = (s_axi_wstrb != '1) ||
                       (s_axi_wdata[PATTERN_WORD_W-1:0] != expected);
    assign proto_bad = (s_axi_wlast != is_last);
    assign beat_err  = data_bad || proto_bad;

    assign s_axi_awready = !aw_full;
    assign s_axi_wready  = !aw_empty && !b_full;
    assign s_axi_bvalid  = !b_empty;
    assign s_axi_bid     = b_head.id[ID_WIDTH-1:0];
    assign s_axi_bresp   = b_head.err ? BRESP_SLVERR : BRESP_OKAY;

    sync_fifo #(
        .WIDTH ($bits(aw_entry_t)),
        .DEPTH (OUTSTANDING)
    ) u_aw_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (aw_push),
        .wdata (aw_in),
        .pop   (burst_end),
        .rdata (aw_head),
        .full  (aw_full),
        .empty (aw_empty)
    );

    sync_fifo #(
        .WIDTH ($bits(b_entry_t)),
        .DEPTH (OUTSTANDING)
    ) u_b_q (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (burst_end),
        .wdata (b_in),
        .pop   (b_pop),
        .rdata (b_head),
        .full  (b_full),
        .empty (b_empty)
    );

    // Beat position inside the head burst and the burst's accumulated error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_idx  <= '0;
            burst_bad <= 1'b0;
        end else if (beat) begin
            if (is_last) begin
                beat_idx  <= '0;
                burst_bad <= 1'b0;
            end else begin
                beat_idx  <= beat_idx + 8'd1;
                burst_bad <= burst_bad || beat_err;
            end
        end
    end

    // Expected pattern word: reloaded on start, otherwise advances per beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected <= '0;
        end else if (chk_start_pulse) begin
            expected <= chk_init_data;
        end else if (beat) begin
            expected <= expected + 32'd1;
        end
    end

    // Run statistics, sticky flags and completion pulse; start overrides same-cycle events
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_received <= '0;
            bursts_done    <= '0;
            data_error     <= 1'b0;
            proto_error    <= 1'b0;
            first_err_beat <= '0;
            done_pulse     <= 1'b0;
        end else if (chk_start_pulse) begin
            beats_received <= '0;
            bursts_done    <= '0;
            data_error     <= 1'b0;
            proto_error    <= 1'b0;
            first_err_beat <= '0;
            done_pulse     <= 1'b0;
        end else begin
            done_pulse <= b_pop && (chk_number != '0) &&
                          ((bursts_done + 32'd1) == chk_number);
            if (beat) begin
                beats_received <= beats_received + 40'd1;
                if (data_bad && !data_error) begin
                    data_error     <= 1'b1;
                    first_err_beat <= beats_received;
                end
                if (proto_bad) begin
                    proto_error <= 1'b1;
                end
            end
            if (b_pop) begin
                bursts_done <= bursts_done + 32'd1;
            end
        end
    end

    // Address-side attributes and upper data lanes carry no information here
    logic unused_inputs;
    assign unused_inputs = ^{s_axi_awaddr, s_axi_awsize, s_axi_awburst,
                             s_axi_awuser, s_axi_wdata, b_head.id};

endmodule

// File: tb/tb_axi_wr_slave_checker.sv
// Self-checking bench for axi_wr_slave_checker: directed table, hand-written
// corner sequences and randomized bursts against a burst-level reference model.
`timescale 1ns/1ps
module tb_axi_wr_slave_checker;

    localparam int IDW = 2;
    localparam int DW  = 64;
    localparam int SW  = DW/8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [IDW-1:0] s_axi_awid;
    logic [63:0]    s_axi_awaddr;
    logic [7:0]     s_axi_awlen;
    logic [2:0]     s_axi_awsize;
    logic [1:0]     s_axi_awburst;
    logic [7:0]     s_axi_awuser;
    logic           s_axi_awvalid;
    logic           s_axi_awready;
    logic [DW-1:0]  s_axi_wdata;
    logic [SW-1:0]  s_axi_wstrb;
    logic           s_axi_wlast;
    logic           s_axi_wvalid;
    logic           s_axi_wready;
    logic [IDW-1:0] s_axi_bid;
    logic [1:0]     s_axi_bresp;
    logic           s_axi_bvalid;
    logic           s_axi_bready;
    logic           chk_start_pulse;
    logic [31:0]    chk_init_data;
    logic [31:0]    chk_number;
    logic [39:0]    beats_received;
    logic [31:0]    bursts_done;
    logic           data_error;
    logic           proto_error;
    logic [39:0]    first_err_beat;
    logic           done_pulse;

    always #5 clk = ~clk;

    axi_wr_slave_checker #(
        .ID_WIDTH     (IDW),
        .ADDR_WIDTH   (64),
        .DATA_WIDTH   (DW),
        .AWUSER_WIDTH (8),
        .OUTSTANDING  (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axi_awid      (s_axi_awid),
        .s_axi_awaddr    (s_axi_awaddr),
        .s_axi_awlen     (s_axi_awlen),
        .s_axi_awsize    (s_axi_awsize),
        .s_axi_awburst   (s_axi_awburst),
        .s_axi_awuser    (s_axi_awuser),
        .s_axi_awvalid   (s_axi_awvalid),
        .s_axi_awready   (s_axi_awready),
        .s_axi_wdata     (s_axi_wdata),
        .s_axi_wstrb     (s_axi_wstrb),
        .s_axi_wlast     (s_axi_wlast),
        .s_axi_wvalid    (s_axi_wvalid),
        .s_axi_wready    (s_axi_wready),
        .s_axi_bid       (s_axi_bid),
        .s_axi_bresp     (s_axi_bresp),
        .s_axi_bvalid    (s_axi_bvalid),
        .s_axi_bready    (s_axi_bready),
        .chk_start_pulse (chk_start_pulse),
        .chk_init_data   (chk_init_data),
        .chk_number      (chk_number),
        .beats_received  (beats_received),
        .bursts_done     (bursts_done),
        .data_error      (data_error),
        .proto_error     (proto_error),
        .first_err_beat  (first_err_beat),
        .done_pulse      (done_pulse)
    );

    typedef enum int {E_NONE, E_DATA, E_STRB, E_WLAST} err_kind_t;

    typedef struct {
        logic [1:0] id;
        int         len;
        int         err_beat;
        err_kind_t  kind;
        logic [1:0] bresp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model state for the current run
    logic [31:0]     m_pat;
    longint unsigned m_beats;
    longint unsigned m_first;
    int unsigned     m_hs;
    int unsigned     m_num;
    logic            m_derr;
    logic            m_perr;
    logic [3:0]      exp_b[$];   // {bid, bresp} in issue order

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic start_run(input logic [31:0] init, input logic [31:0] num);
        @(posedge clk); #1;
        chk_start_pulse = 1'b1;
        chk_init_data   = init;
        chk_number      = num;
        @(posedge clk); #1;
        chk_start_pulse = 1'b0;
        m_pat = init; m_beats = 0; m_first = 0; m_hs = 0; m_num = num;
        m_derr = 1'b0; m_perr = 1'b0;
    endtask

    task automatic send_aw(input logic [1:0] id, input int len);
        int t;
        t = 0;
        s_axi_awid    = id;
        s_axi_awlen   = 8'(len);
        s_axi_awaddr  = {$urandom(), $urandom()};
        s_axi_awuser  = 8'($urandom());
        s_axi_awvalid = 1'b1;
        do begin
            @(negedge clk); t++;
        end while (!s_axi_awready && t < 500);
        if (!s_axi_awready) check("aw_timeout", 64'(s_axi_awready), 64'd1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    // Drives one burst; the model derives the burst's response unless a table value is given
    task automatic send_w(input logic [1:0] id, input int len, input int eb, input err_kind_t k,
                          input logic use_tab, input logic [1:0] tab_resp);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i <= len; i++) begin
            logic [31:0]   w;
            logic [SW-1:0] s;
            logic          l;
            logic          d;
            logic          p;
            int            t;
            w = m_pat; s = '1; l = (i == len); t = 0;
            if (i == eb) begin
                case (k)
                    E_DATA:  w = 32'hDEAD;
                    E_STRB:  s[0] = 1'b0;
                    E_WLAST: l = !l;
                    default: ;
                endcase
            end
            s_axi_wdata  = {$urandom(), w};
            s_axi_wstrb  = s;
            s_axi_wlast  = l;
            s_axi_wvalid = 1'b1;
            do begin
                @(negedge clk); t++;
            end while (!s_axi_wready && t < 500);
            if (!s_axi_wready) check("w_timeout", 64'(s_axi_wready), 64'd1);
            @(posedge clk); #1;
            d = (w != m_pat) || (s != '1);
            p = (l != (i == len));
            if (d && !m_derr) begin
                m_derr  = 1'b1;
                m_first = m_beats;
            end
            if (p) m_perr = 1'b1;
            bad = bad || d || p;
            m_beats++;
            m_pat = m_pat + 32'd1;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        exp_b.push_back({id, use_tab ? tab_resp : (bad ? 2'b10 : 2'b00)});
    endtask

    // Accepts n B responses in order and checks done_pulse every cycle
    task automatic collect(input int n);
        int         got;
        int         t;
        logic       pend;
        logic [3:0] e;
        got = 0; t = 0; pend = 1'b0;
        s_axi_bready = 1'b1;
        while (got < n && t < 2000) begin
            @(negedge clk); t++;
            check("done_pulse", 64'(done_pulse), 64'(pend));
            pend = 1'b0;
            if (s_axi_bvalid) begin
                got++;
                if (exp_b.size() == 0) begin
                    check("b_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_b.pop_front();
                    check("bid", 64'(s_axi_bid), 64'(e[3:2]));
                    check("bresp", 64'(s_axi_bresp), 64'(e[1:0]));
                end
                m_hs++;
                pend = (m_num != 0) && (m_hs == m_num);
            end
        end
        if (got < n) check("b_timeout", 64'(got), 64'(n));
        @(negedge clk);
        check("done_pulse", 64'(done_pulse), 64'(pend));
        s_axi_bready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_status(input string tag);
        @(negedge clk);
        check({tag, "_beats"},  64'(beats_received), m_beats);
        check({tag, "_bursts"}, 64'(bursts_done), 64'(m_hs));
        check({tag, "_derr"},   64'(data_error), 64'(m_derr));
        check({tag, "_perr"},   64'(proto_error), 64'(m_perr));
        check({tag, "_first"},  64'(first_err_beat), m_first);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_awready"}, 64'(s_axi_awready), 64'd1);
        check({tag, "_wready"},  64'(s_axi_wready), 64'd0);
        check({tag, "_bvalid"},  64'(s_axi_bvalid), 64'd0);
        check({tag, "_bid"},     64'(s_axi_bid), 64'd0);
        check({tag, "_bresp"},   64'(s_axi_bresp), 64'd0);
        check({tag, "_beats"},   64'(beats_received), 64'd0);
        check({tag, "_bursts"},  64'(bursts_done), 64'd0);
        check({tag, "_derr"},    64'(data_error), 64'd0);
        check({tag, "_perr"},    64'(proto_error), 64'd0);
        check({tag, "_first"},   64'(first_err_beat), 64'd0);
        check({tag, "_done"},    64'(done_pulse), 64'd0);
    endtask

    task automatic run_random(input int total);
        int left;
        left = total;
        while (left > 0) begin
            logic [1:0] ids[4];
            int         lens[4];
            int         ebs[4];
            err_kind_t  ks[4];
            int         g;
            g = int'($urandom_range(1, (left < 4) ? left : 4));
            for (int j = 0; j < g; j++) begin
                ids[j]  = 2'($urandom());
                lens[j] = int'($urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) begin
                    ks[j]  = err_kind_t'($urandom_range(1, 3));
                    ebs[j] = int'($urandom_range(0, lens[j]));
                end else begin
                    ks[j]  = E_NONE;
                    ebs[j] = -1;
                end
            end
            for (int j = 0; j < g; j++) send_aw(ids[j], lens[j]);
            for (int j = 0; j < g; j++) send_w(ids[j], lens[j], ebs[j], ks[j], 1'b0, 2'b00);
            collect(g);
            left -= g;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab[6];

        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd6;
        s_axi_awburst = 2'b01; s_axi_awuser = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0; chk_start_pulse = 1'b0; chk_init_data = '0; chk_number = '0;
        m_pat = '0; m_beats = 0; m_first = 0; m_hs = 0; m_num = 0; m_derr = 1'b0; m_perr = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single clean burst, done after one burst
        start_run(32'h100, 32'd1);
        send_aw(2'd1, 3);
        send_w(2'd1, 3, -1, E_NONE, 1'b1, 2'b00);
        collect(1);
        check_status("single");

        // Directed table: {id, len, err_beat, kind, expected bresp}
        tab[0] = '{2'd2, 3,  2, E_DATA,  2'b10};
        tab[1] = '{2'd3, 3, -1, E_NONE,  2'b00};
        tab[2] = '{2'd0, 3,  1, E_WLAST, 2'b10};
        tab[3] = '{2'd1, 0,  0, E_STRB,  2'b10};
        tab[4] = '{2'd2, 7, -1, E_NONE,  2'b00};
        tab[5] = '{2'd3, 0,  0, E_WLAST, 2'b10};
        start_run(32'h1000, 32'd6);
        for (int i = 0; i < 6; i++) begin
            send_aw(tab[i].id, tab[i].len);
            send_w(tab[i].id, tab[i].len, tab[i].err_beat, tab[i].kind, 1'b1, tab[i].bresp);
            collect(1);
        end
        @(negedge clk);
        check("tab_first_err_beat", 64'(first_err_beat), 64'd2);
        check("tab_beats", 64'(beats_received), 64'd22);
        check("tab_proto_error", 64'(proto_error), 64'd1);
        @(posedge clk); #1;
        check_status("tab");

        // Eight bursts with bready low: AW queue fills, responses drain in order
        start_run(32'hABCD_0000, 32'd8);
        for (int i = 0; i < 8; i++) send_aw(2'(i % 4), 15);
        s_axi_awvalid = 1'b1;
        @(negedge clk);
        check("aw_full_awready", 64'(s_axi_awready), 64'd0);
        s_axi_awvalid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send_w(2'(i % 4), 15, -1, E_NONE, 1'b0, 2'b00);
        @(negedge clk);
        check("eight_bvalid_held", 64'(s_axi_bvalid), 64'd1);
        check("eight_bursts_pending", 64'(bursts_done), 64'd0);
        @(posedge clk); #1;
        collect(8);
        @(negedge clk);
        check("eight_bursts_done", 64'(bursts_done), 64'd8);
        @(posedge clk); #1;
        check_status("eight");

        // W offered before AW: wready only after the AW handshake
        start_run(32'h0, 32'd0);
        s_axi_wdata  = '0;
        s_axi_wstrb  = '1;
        s_axi_wvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("w_before_aw_wready", 64'(s_axi_wready), 64'd0);
        end
        @(posedge clk); #1;
        s_axi_awid = 2'd2; s_axi_awlen = 8'd1; s_axi_awvalid = 1'b1;
        @(negedge clk);
        check("w_before_aw_awready", 64'(s_axi_awready), 64'd1);
        check("w_at_aw_wready", 64'(s_axi_wready), 64'd0);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        @(negedge clk);
        check("w_after_aw_wready", 64'(s_axi_wready), 64'd1);
        s_axi_wvalid = 1'b0;
        @(posedge clk); #1;
        send_w(2'd2, 1, -1, E_NONE, 1'b0, 2'b00);
        collect(1);
        check_status("wfirst");

        // Reset in the middle of a burst, then a fresh single-beat burst
        start_run(32'h55, 32'd0);
        send_aw(2'd0, 3);
        s_axi_wvalid = 1'b1; s_axi_wstrb = '1;
        for (int i = 0; i < 2; i++) begin
            s_axi_wdata = 64'(32'h55 + i);
            @(posedge clk); #1;
        end
        s_axi_wvalid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_b.delete();
        @(negedge clk);
        check("midrst_wready_after", 64'(s_axi_wready), 64'd0);
        @(posedge clk); #1;
        start_run(32'h0, 32'd1);
        send_aw(2'd3, 0);
        send_w(2'd3, 0, -1, E_NONE, 1'b1, 2'b00);
        collect(1);
        check_status("postrst");

        // Randomized bursts against the model
        start_run($urandom(), 32'd12);
        run_random(12);
        check_status("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
